// File: rtl/data_mem_stage_if.sv
// Bundle between data_mem_stage, the PSR1 register, the
// register file and the data RAM. Optional: DCACHE_STATS_EN.
interface data_mem_stage_if #(
   parameter int D_WIDTH = 8,
   parameter int A_WIDTH = 8
);
   logic               psr1_valid;
   logic [1:0]         psr1_op;
   logic [3:0]         psr1_rd;
   logic [D_WIDTH-1:0] psr1_res;
   logic [D_WIDTH-1:0] psr1_sdata;
   logic [2:0]         psr1_flags;
   logic               stall;
   logic               wb_en;
   logic [3:0]         wb_addr;
   logic [D_WIDTH-1:0] wb_data;
   logic [2:0]         flags_out;
   logic               ram_req;
   logic               ram_rw;
   logic [A_WIDTH-1:0] ram_addr;
   logic [D_WIDTH-1:0] ram_wdata;
   logic [D_WIDTH-1:0] ram_rdata;
   logic               ram_ack;
`ifdef DCACHE_STATS_EN
   logic [7:0]         hit_cnt;
   logic [7:0]         miss_cnt;
`endif

   modport slave (
      input  psr1_valid, psr1_op, psr1_rd,
      input  psr1_res, psr1_sdata, psr1_flags,
      input  ram_rdata, ram_ack,
      output stall, wb_en, wb_addr, wb_data,
      output flags_out,
`ifdef DCACHE_STATS_EN
      output hit_cnt, miss_cnt,
`endif
      output ram_req, ram_rw, ram_addr, ram_wdata
   );

   modport master (
      output psr1_valid, psr1_op, psr1_rd,
      output psr1_res, psr1_sdata, psr1_flags,
      output ram_rdata, ram_ack,
      input  stall, wb_en, wb_addr, wb_data,
      input  flags_out,
`ifdef DCACHE_STATS_EN
      input  hit_cnt, miss_cnt,
`endif
      input  ram_req, ram_rw, ram_addr, ram_wdata
   );
endinterface

// File: rtl/data_mem_stage.sv
// Pipeline stage 3: direct-mapped write-through D-cache,
// RAM access and write-back. Optional: DCACHE_STATS_EN.
module data_mem_stage #(
   parameter int D_WIDTH  = 8,
   parameter int A_WIDTH  = 8,
   parameter int IDX_BITS = 2
) (
   input logic             g_clk,
   input logic             g_clr,
   data_mem_stage_if.slave bus
);
   localparam int LINES = 1 << IDX_BITS;
   localparam int TAG_W = A_WIDTH - IDX_BITS;

   typedef enum logic [1:0] {
      IDLE,
      RD_MISS,
      WR_THRU
   } state_t;

   state_t state_q, state_d;

   logic [LINES-1:0]   valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q [LINES];
   logic [TAG_W-1:0]   tag_d [LINES];
   logic [D_WIDTH-1:0] data_q [LINES];
   logic [D_WIDTH-1:0] data_d [LINES];

   logic               wb_en_q, wb_en_d;
   logic [3:0]         wb_addr_q, wb_addr_d;
   logic [D_WIDTH-1:0] wb_data_q, wb_data_d;
   logic [2:0]         flags_q, flags_d;
   logic               ram_req_q, ram_req_d;
   logic               ram_rw_q, ram_rw_d;
   logic [A_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [D_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
   logic [3:0]         pend_rd_q, pend_rd_d;
   logic [2:0]         pend_fl_q, pend_fl_d;
   logic               stall_c;

`ifdef DCACHE_STATS_EN
   logic [7:0] hit_q, hit_d;
   logic [7:0] miss_q, miss_d;
`endif

   logic [A_WIDTH-1:0]  addr;
   logic [IDX_BITS-1:0] idx;
   logic [TAG_W-1:0]    tag;
   logic [IDX_BITS-1:0] f_idx;
   logic [TAG_W-1:0]    f_tag;
   logic                hit;
   logic                live;
   logic                is_alu;
   logic                is_ld;
   logic                is_st;

   assign addr  = bus.psr1_res[A_WIDTH-1:0];
   assign idx   = addr[IDX_BITS-1:0];
   assign tag   = addr[A_WIDTH-1:IDX_BITS];
   assign f_idx = ram_addr_q[IDX_BITS-1:0];
   assign f_tag = ram_addr_q[A_WIDTH-1:IDX_BITS];
   assign hit   = valid_q[idx] && (tag_q[idx] == tag);
   assign live  = bus.psr1_valid && (state_q == IDLE);
   assign is_alu = live && (bus.psr1_op == 2'b00);
   assign is_ld  = live && (bus.psr1_op == 2'b01);
   assign is_st  = live && (bus.psr1_op == 2'b10);

   // Next-state, cache update and stall decode
   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      tag_d       = tag_q;
      data_d      = data_q;
      wb_en_d     = 1'b0;
      wb_addr_d   = wb_addr_q;
      wb_data_d   = wb_data_q;
      flags_d     = flags_q;
      ram_req_d   = ram_req_q;
      ram_rw_d    = ram_rw_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      pend_rd_d   = pend_rd_q;
      pend_fl_d   = pend_fl_q;
      stall_c     = 1'b0;
`ifdef DCACHE_STATS_EN
      hit_d  = hit_q;
      miss_d = miss_q;
      if (is_ld || is_st) begin
         if (hit) begin
            if (hit_q != 8'hFF) hit_d = hit_q + 8'd1;
         end else begin
            if (miss_q != 8'hFF) miss_d = miss_q + 8'd1;
         end
      end
`endif
      unique case (state_q)
         IDLE: begin
            unique case (1'b1)
               is_alu: begin
                  wb_en_d   = 1'b1;
                  wb_addr_d = bus.psr1_rd;
                  wb_data_d = bus.psr1_res;
                  flags_d   = bus.psr1_flags;
               end
               (is_ld && hit): begin
                  wb_en_d   = 1'b1;
                  wb_addr_d = bus.psr1_rd;
                  wb_data_d = data_q[idx];
                  flags_d   = bus.psr1_flags;
               end
               (is_ld && !hit): begin
                  stall_c    = 1'b1;
                  state_d    = RD_MISS;
                  ram_req_d  = 1'b1;
                  ram_rw_d   = 1'b1;
                  ram_addr_d = addr;
                  pend_rd_d  = bus.psr1_rd;
                  pend_fl_d  = bus.psr1_flags;
               end
               is_st: begin
                  stall_c     = 1'b1;
                  state_d     = WR_THRU;
                  ram_req_d   = 1'b1;
                  ram_rw_d    = 1'b0;
                  ram_addr_d  = addr;
                  ram_wdata_d = bus.psr1_sdata;
                  pend_fl_d   = bus.psr1_flags;
                  if (hit) data_d[idx] = bus.psr1_sdata;
               end
               default: ;
            endcase
         end
         RD_MISS: begin
            stall_c = !bus.ram_ack;
            if (bus.ram_ack) begin
               valid_d[f_idx] = 1'b1;
               tag_d[f_idx]   = f_tag;
               data_d[f_idx]  = bus.ram_rdata;
               wb_en_d        = 1'b1;
               wb_addr_d      = pend_rd_q;
               wb_data_d      = bus.ram_rdata;
               flags_d        = pend_fl_q;
               ram_req_d      = 1'b0;
               state_d        = IDLE;
            end
         end
         WR_THRU: begin
            stall_c = !bus.ram_ack;
            if (bus.ram_ack) begin
               flags_d   = pend_fl_q;
               ram_req_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, cache and output registers
   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         for (int i = 0; i < LINES; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
         wb_en_q     <= 1'b0;
         wb_addr_q   <= '0;
         wb_data_q   <= '0;
         flags_q     <= '0;
         ram_req_q   <= 1'b0;
         ram_rw_q    <= 1'b1;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         pend_rd_q   <= '0;
         pend_fl_q   <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         tag_q       <= tag_d;
         data_q      <= data_d;
         wb_en_q     <= wb_en_d;
         wb_addr_q   <= wb_addr_d;
         wb_data_q   <= wb_data_d;
         flags_q     <= flags_d;
         ram_req_q   <= ram_req_d;
         ram_rw_q    <= ram_rw_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         pend_rd_q   <= pend_rd_d;
         pend_fl_q   <= pend_fl_d;
      end
   end

`ifdef DCACHE_STATS_EN
   // Saturating hit/miss counters
   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         hit_q  <= hit_d;
         miss_q <= miss_d;
      end
   end

   assign bus.hit_cnt  = hit_q;
   assign bus.miss_cnt = miss_q;
`endif

   assign bus.stall     = stall_c;
   assign bus.wb_en     = wb_en_q;
   assign bus.wb_addr   = wb_addr_q;
   assign bus.wb_data   = wb_data_q;
   assign bus.flags_out = flags_q;
   assign bus.ram_req   = ram_req_q;
   assign bus.ram_rw    = ram_rw_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
endmodule
